lcd_timing_gen: RTL and testbench

Parametrised successor to the fixed 480x272 colour-bar LCD driver. It generates full RGB565 panel timing: HSYNC, VSYNC and DE, with selectable sync polarity. It also produces a selectable test pattern and exports pixel coordinates and frame strobes so downstream pixel sources can replace the pattern generator. It sits between the PixelClk domain root and the LCD pads.

---
 rtl/lcd_timing_gen_pkg.sv | 17 +
 rtl/lcd_timing_gen_if.sv | 16 +
 rtl/lcd_timing_gen_pattern_gen.sv | 64 ++++++
 rtl/lcd_timing_gen.sv | 96 +++++++++
 tb/tb_lcd_timing_gen.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/lcd_timing_gen_pkg.sv
// lcd_pkg: shared pattern/colour types and default 480x272 panel timing
package lcd_pkg;
  typedef enum logic [1:0] {PAT_BAR, PAT_RAMP, PAT_CHECK, PAT_SOLID} pattern_e;
  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;
  localparam int DEF_H_ACTIVE = 480;
  localparam int DEF_H_FP     = 8;
  localparam int DEF_H_SYNC   = 4;
  localparam int DEF_H_BP     = 43;
  localparam int DEF_V_ACTIVE = 272;
  localparam int DEF_V_FP     = 8;
  localparam int DEF_V_SYNC   = 4;
  localparam int DEF_V_BP     = 12;
endpackage

// File: rtl/lcd_timing_gen_if.sv
// lcd_timing_gen_if: panel pad bundle plus coordinate/frame side-band
// master drives DE/HSYNC/VSYNC/RGB565, pix_x/pix_y, frame_start, frame_count; slave observes
interface lcd_timing_gen_if #(parameter int CNT_W = 11);
  logic             LCD_DE;
  logic             LCD_HSYNC;
  logic             LCD_VSYNC;
  logic [4:0]       LCD_R;
  logic [5:0]       LCD_G;
  logic [4:0]       LCD_B;
  logic [CNT_W-1:0] pix_x;
  logic [CNT_W-1:0] pix_y;
  logic             frame_start;
  logic [15:0]      frame_count;
  modport master(output LCD_DE, LCD_HSYNC, LCD_VSYNC, LCD_R, LCD_G, LCD_B, pix_x, pix_y, frame_start, frame_count);
  modport slave(input LCD_DE, LCD_HSYNC, LCD_VSYNC, LCD_R, LCD_G, LCD_B, pix_x, pix_y, frame_start, frame_count);
endinterface

// File: rtl/lcd_timing_gen_pattern_gen.sv
// lcd_pattern_gen: test pattern colour for the current active pixel
// PixelClk/nRST clock and async reset; de_i advances the bar/ramp accumulators; x_i/y_i active coords;
// sel_i/solid_i shadowed pattern choice; rgb_o combinational colour
module lcd_pattern_gen
  import lcd_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int CHK_LOG2 = 4,
  parameter int CNT_W    = 11
) (
  input  logic             PixelClk,
  input  logic             nRST,
  input  logic             de_i,
  input  logic [CNT_W-1:0] x_i,
  input  logic [CNT_W-1:0] y_i,
  input  pattern_e         sel_i,
  input  rgb565_t          solid_i,
  output rgb565_t          rgb_o
);
  localparam int BAR_W = H_ACTIVE / 16;
  localparam logic [CNT_W+1:0] H1 = (CNT_W+2)'(H_ACTIVE);
  localparam logic [CNT_W+1:0] H2 = (CNT_W+2)'(2 * H_ACTIVE);
  localparam logic [CNT_W+1:0] H3 = (CNT_W+2)'(3 * H_ACTIVE);
  localparam logic [CNT_W+1:0] H4 = (CNT_W+2)'(4 * H_ACTIVE);
  logic [CNT_W-1:0] pos_q, pos_d, rem_q, rem_d;
  logic [3:0]       bar_q, bar_d;
  logic [5:0]       g_q, g_d;
  logic [CNT_W+1:0] s, rem_n;
  logic [2:0]       g_inc;
  logic             adv, bar_end, chk;
  rgb565_t          bar_c, ramp_c;
  // accumulators track x of the current pixel; they clear in blanking and after the last pixel of a line
  // ramp keeps x*64 = g*H_ACTIVE + rem; since H_ACTIVE >= 16 a step adds at most 4 to g
  always_comb begin
    adv     = de_i && x_i != CNT_W'(H_ACTIVE - 1);
    bar_end = pos_q == CNT_W'(BAR_W - 1);
    pos_d   = (adv && !bar_end) ? pos_q + 1'b1 : '0;
    bar_d   = !adv ? '0 : (bar_end && bar_q != 4'd15) ? bar_q + 1'b1 : bar_q;
    s       = (CNT_W+2)'(rem_q) + (CNT_W+2)'(64);
    rem_n   = s >= H4 ? s - H4 : s >= H3 ? s - H3 : s >= H2 ? s - H2 : s >= H1 ? s - H1 : s;
    g_inc   = s >= H4 ? 3'd4 : s >= H3 ? 3'd3 : s >= H2 ? 3'd2 : s >= H1 ? 3'd1 : 3'd0;
    rem_d   = adv ? CNT_W'(rem_n) : '0;
    g_d     = adv ? g_q + 6'(g_inc) : '0;
    bar_c.r = bar_q < 4'd5 ? 5'd1 << bar_q : '0;
    bar_c.g = (bar_q >= 4'd5 && bar_q < 4'd11) ? 6'd1 << (bar_q - 4'd5) : '0;
    bar_c.b = bar_q >= 4'd11 ? 5'd1 << (bar_q - 4'd11) : '0;
    ramp_c  = {g_q[5:1], g_q, g_q[5:1]};
    chk     = |(((x_i ^ y_i) >> CHK_LOG2) & CNT_W'(1));
    rgb_o   = sel_i == PAT_BAR ? bar_c : sel_i == PAT_RAMP ? ramp_c : sel_i == PAT_CHECK ? {16{chk}} : solid_i;
  end
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      pos_q <= '0;
      bar_q <= '0;
      rem_q <= '0;
      g_q   <= '0;
    end else begin
      pos_q <= pos_d;
      bar_q <= bar_d;
      rem_q <= rem_d;
      g_q   <= g_d;
    end
  end
endmodule

// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: parametrised RGB565 panel timing with test patterns and frame strobes
// PixelClk pixel clock; nRST async active-low reset; pattern_sel/solid_rgb pattern choice (latched at frame start);
// lcd master bundle: DE/HSYNC/VSYNC/RGB, pix_x/pix_y, frame_start, frame_count, all registered
module lcd_timing_gen
  import lcd_pkg::*;
#(
  parameter int H_ACTIVE     = DEF_H_ACTIVE,
  parameter int H_FP         = DEF_H_FP,
  parameter int H_SYNC       = DEF_H_SYNC,
  parameter int H_BP         = DEF_H_BP,
  parameter int V_ACTIVE     = DEF_V_ACTIVE,
  parameter int V_FP         = DEF_V_FP,
  parameter int V_SYNC       = DEF_V_SYNC,
  parameter int V_BP         = DEF_V_BP,
  parameter int SYNC_ACT_LOW = 1,
  parameter int CHK_LOG2     = 4,
  parameter int CNT_W        = 11
) (
  input  logic              PixelClk,
  input  logic              nRST,
  input  logic [1:0]        pattern_sel,
  input  logic [15:0]       solid_rgb,
  lcd_timing_gen_if.master  lcd
);
  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int H_A0 = H_SYNC + H_BP;
  localparam int V_A0 = V_SYNC + V_BP;
  localparam logic SYNC_IDLE = SYNC_ACT_LOW != 0;
  if (H_TOTAL >= 2**CNT_W || V_TOTAL >= 2**CNT_W || H_ACTIVE < 16) begin : g_bad_cfg
    $fatal(1, "lcd_timing_gen: timing does not fit CNT_W or H_ACTIVE < 16");
  end
  logic [CNT_W-1:0] h_q, h_d, v_q, v_d, x, y;
  logic [15:0]      fc_q, fc_d;
  pattern_e         sel_q;
  rgb565_t          solid_q, pat, rgb_d;
  logic             h_wrap, v_wrap, de, frame0;
  always_comb begin
    h_wrap = h_q == CNT_W'(H_TOTAL - 1);
    v_wrap = v_q == CNT_W'(V_TOTAL - 1);
    h_d    = h_wrap ? '0 : h_q + 1'b1;
    v_d    = !h_wrap ? v_q : v_wrap ? '0 : v_q + 1'b1;
    fc_d   = fc_q + 16'(h_wrap && v_wrap);
    de     = h_q >= CNT_W'(H_A0) && h_q < CNT_W'(H_A0 + H_ACTIVE) && v_q >= CNT_W'(V_A0) && v_q < CNT_W'(V_A0 + V_ACTIVE);
    x      = de ? h_q - CNT_W'(H_A0) : '0;
    y      = de ? v_q - CNT_W'(V_A0) : '0;
    frame0 = h_q == '0 && v_q == '0;
    rgb_d  = de ? pat : '0;
  end
  lcd_pattern_gen #(.H_ACTIVE(H_ACTIVE), .CHK_LOG2(CHK_LOG2), .CNT_W(CNT_W)) u_pat (
    .PixelClk(PixelClk),
    .nRST(nRST),
    .de_i(de),
    .x_i(x),
    .y_i(y),
    .sel_i(sel_q),
    .solid_i(solid_q),
    .rgb_o(pat)
  );
  // the shadow updates only at (0,0), which lies in blanking, so a whole frame uses one pattern
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      h_q             <= '0;
      v_q             <= '0;
      fc_q            <= '0;
      sel_q           <= PAT_BAR;
      solid_q         <= '0;
      lcd.LCD_DE      <= 1'b0;
      lcd.LCD_HSYNC   <= SYNC_IDLE;
      lcd.LCD_VSYNC   <= SYNC_IDLE;
      lcd.LCD_R       <= '0;
      lcd.LCD_G       <= '0;
      lcd.LCD_B       <= '0;
      lcd.pix_x       <= '0;
      lcd.pix_y       <= '0;
      lcd.frame_start <= 1'b0;
      lcd.frame_count <= '0;
    end else begin
      h_q             <= h_d;
      v_q             <= v_d;
      fc_q            <= fc_d;
      sel_q           <= frame0 ? pattern_e'(pattern_sel) : sel_q;
      solid_q         <= frame0 ? rgb565_t'(solid_rgb) : solid_q;
      lcd.LCD_DE      <= de;
      lcd.LCD_HSYNC   <= h_q < CNT_W'(H_SYNC) ? ~SYNC_IDLE : SYNC_IDLE;
      lcd.LCD_VSYNC   <= v_q < CNT_W'(V_SYNC) ? ~SYNC_IDLE : SYNC_IDLE;
      lcd.LCD_R       <= rgb_d.r;
      lcd.LCD_G       <= rgb_d.g;
      lcd.LCD_B       <= rgb_d.b;
      lcd.pix_x       <= x;
      lcd.pix_y       <= y;
      lcd.frame_start <= frame0;
      lcd.frame_count <= fc_d;
    end
  end
endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb_lcd_timing_gen: default, tiny active-high and mid-size instances checked every cycle against an arithmetic model
module tb_lcd_timing_gen;
  localparam int NI = 3;
  localparam int HA[NI]  = '{480, 16, 40};
  localparam int HF[NI]  = '{8, 2, 3};
  localparam int HS[NI]  = '{4, 1, 2};
  localparam int HB[NI]  = '{43, 3, 5};
  localparam int VA[NI]  = '{272, 6, 5};
  localparam int VF[NI]  = '{8, 1, 2};
  localparam int VS[NI]  = '{4, 2, 1};
  localparam int VB[NI]  = '{12, 1, 2};
  localparam int SAL[NI] = '{1, 0, 1};
  localparam int CHK[NI] = '{4, 1, 2};
  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [15:0] rgb;
    logic [10:0] x;
    logic [10:0] y;
    logic        fs;
    logic [15:0] fc;
  } obs_t;
  logic PixelClk = 1'b0;
  logic nRST = 1'b0;
  logic [1:0] pattern_sel = 2'd0;
  logic [15:0] solid_rgb = 16'd0;
  obs_t act[NI];
  obs_t exp_o[NI];
  int sh_sel[NI];
  int sh_rgb[NI];
  int e = 0;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 PixelClk = ~PixelClk;
  for (genvar i = 0; i < NI; i++) begin : g_dut
    lcd_timing_gen_if #(.CNT_W(11)) lif ();
    lcd_timing_gen #(
      .H_ACTIVE(HA[i]), .H_FP(HF[i]), .H_SYNC(HS[i]), .H_BP(HB[i]),
      .V_ACTIVE(VA[i]), .V_FP(VF[i]), .V_SYNC(VS[i]), .V_BP(VB[i]),
      .SYNC_ACT_LOW(SAL[i]), .CHK_LOG2(CHK[i]), .CNT_W(11)
    ) dut (
      .PixelClk(PixelClk),
      .nRST(nRST),
      .pattern_sel(pattern_sel),
      .solid_rgb(solid_rgb),
      .lcd(lif)
    );
    assign act[i] = {lif.LCD_DE, lif.LCD_HSYNC, lif.LCD_VSYNC, lif.LCD_R, lif.LCD_G, lif.LCD_B,
                     lif.pix_x, lif.pix_y, lif.frame_start, lif.frame_count};
  end
  function automatic int frame_len(int i);
    return (HS[i] + HB[i] + HA[i] + HF[i]) * (VS[i] + VB[i] + VA[i] + VF[i]);
  endfunction
  function automatic obs_t rst_obs(int i);
    obs_t o = '0;
    o.hs = SAL[i] != 0;
    o.vs = SAL[i] != 0;
    return o;
  endfunction
  // outputs after the edge that consumes counter state index k (k edges after release)
  function automatic obs_t model(int i, int k, int sel, int sol);
    obs_t o = '0;
    int ht = HS[i] + HB[i] + HA[i] + HF[i];
    int vt = VS[i] + VB[i] + VA[i] + VF[i];
    int n = ht * vt;
    int h = k % ht;
    int v = (k / ht) % vt;
    int hb = HS[i] + HB[i];
    int vb = VS[i] + VB[i];
    int x, y, b, g;
    o.de = h >= hb && h < hb + HA[i] && v >= vb && v < vb + VA[i];
    o.hs = (h < HS[i]) != (SAL[i] != 0);
    o.vs = (v < VS[i]) != (SAL[i] != 0);
    x = o.de ? h - hb : 0;
    y = o.de ? v - vb : 0;
    o.x = 11'(x);
    o.y = 11'(y);
    if (o.de) begin
      case (sel)
        0: begin
          b = x / (HA[i] / 16);
          if (b > 15) b = 15;
          o.rgb = b < 5 ? 16'((1 << b) << 11) : b < 11 ? 16'((1 << (b - 5)) << 5) : 16'(1 << (b - 11));
        end
        1: begin
          g = x * 64 / HA[i];
          o.rgb = 16'(((g >> 1) << 11) | (g << 5) | (g >> 1));
        end
        2: o.rgb = (((x >> CHK[i]) ^ (y >> CHK[i])) & 1) != 0 ? 16'hFFFF : 16'h0000;
        default: o.rgb = 16'(sol);
      endcase
    end
    o.fs = (k % n) == 0;
    o.fc = 16'((k + 1) / n);
    return o;
  endfunction
  task automatic check(string name, int idx, logic [63:0] got, logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s[%0d] at %0t: got %h expected %h", name, idx, $time, got, want);
    end
  endtask
  always @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      e = 0;
      for (int i = 0; i < NI; i++) begin
        sh_sel[i] = 0;
        sh_rgb[i] = 0;
        exp_o[i] = rst_obs(i);
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        exp_o[i] = model(i, e, sh_sel[i], sh_rgb[i]);
        if (e % frame_len(i) == 0) begin
          sh_sel[i] = int'(pattern_sel);
          sh_rgb[i] = int'(solid_rgb);
        end
      end
      e++;
    end
  end
  always @(negedge PixelClk)
    for (int i = 0; i < NI; i++) check("cycle", i, 64'(act[i]), 64'(exp_o[i]));
  task automatic measure();
    int cyc = 0;
    int hsl = 0;
    int vsl = 0;
    bit seen = 0;
    while (!seen && cyc < 20000) begin
      @(posedge PixelClk);
      #1;
      cyc++;
      if (cyc == 1) check("frame_start_first", 0, 64'(act[0].fs), 64'd1);
      if (!act[0].hs) hsl++;
      if (!act[0].vs) vsl++;
      seen = act[0].de;
    end
    check("de_first_edge", 0, 64'(cyc), 64'd8608);
    check("hsync_low_clocks", 0, 64'(hsl), 64'd68);
    check("vsync_low_clocks", 0, 64'(vsl), 64'd2140);
    check("first_de_xy", 0, 64'({act[0].x, act[0].y}), 64'd0);
  endtask
  task automatic wait_for(int i, bit want_fs);
    int n = 0;
    do begin
      @(negedge PixelClk);
      n++;
    end while ((want_fs ? !act[i].fs : !act[i].de) && n < 600);
    if (n >= 600) check(want_fs ? "wait_frame_start" : "wait_de", i, 64'(n), 64'd0);
  endtask
  initial begin
    obs_t m;
    m = model(0, 8607, 0, 0);
    check("model_first_de", 0, 64'({m.de, m.x, m.y, m.rgb}), {39'd0, 1'b1, 22'd0, 16'h0800});
    m = model(0, 8606, 0, 0);
    check("model_pre_de", 0, 64'(m.de), 64'd0);
    m = model(0, 8607 + 150, 0, 0);
    check("model_bar5", 0, 64'(m.rgb), 64'h0020);
    m = model(0, 8607 + 479, 0, 0);
    check("model_bar15", 0, 64'(m.rgb), 64'h0010);
    m = model(0, 8607 + 240, 1, 0);
    check("model_ramp_mid", 0, 64'(m.rgb), 64'h8410);
    m = model(0, 3, 0, 0);
    check("model_hsync_on", 0, 64'({m.hs, m.vs}), 64'd0);
    m = model(0, 158360, 0, 0);
    check("model_frame2_start", 0, 64'({m.fs, m.fc}), {47'd0, 1'b1, 16'd1});
    m = model(1, 75, 0, 0);
    check("model_tiny_bar", 1, 64'({m.hs, m.rgb}), {47'd0, 1'b0, 16'h0020});
    m = model(1, 72, 2, 0);
    check("model_tiny_check", 1, 64'(m.rgb), 64'hFFFF);
    repeat (3) @(negedge PixelClk);
    nRST = 1'b1;
    measure();
    while (e < 53700) begin
      @(negedge PixelClk);
      if (e % 997 == 0) begin
        pattern_sel = 2'(e / 997);
        solid_rgb = 16'(e * 40503);
      end
    end
    check("pre_reset_de", 0, 64'({act[0].de, act[0].x, act[0].y}), {52'd0, 1'b1, 11'd152, 11'd84});
    check("tiny_frame_count", 1, 64'(act[1].fc), 64'd244);
    check("mid_frame_count", 2, 64'(act[2].fc), 64'd107);
    #1;
    nRST = 1'b0;
    pattern_sel = 2'd0;
    solid_rgb = 16'd0;
    #1;
    for (int i = 0; i < NI; i++) check("async_reset", i, 64'(act[i]), 64'(rst_obs(i)));
    repeat (4) @(negedge PixelClk);
    nRST = 1'b1;
    measure();
    wait_for(1, 1'b1);
    repeat (75) @(negedge PixelClk);
    pattern_sel = 2'd3;
    solid_rgb = 16'hF800;
    wait_for(1, 1'b0);
    check("no_tear", 1, 64'(act[1].rgb == 16'hF800), 64'd0);
    wait_for(1, 1'b1);
    wait_for(1, 1'b0);
    check("solid_next_frame", 1, 64'(act[1].rgb), 64'hF800);
    repeat (300) @(negedge PixelClk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
